// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU op encoding, the
// multiplier FSM states and the control bundle carried through EX/MEM.
package ex_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;
    localparam logic [3:0] ALU_NOR  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_MUL  = 4'd11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } ex_state_e;

    // Control bits that travel alongside the result to MEM/WB.
    typedef struct packed {
        logic       reg_wr;
        logic       mem_wr;
        logic       mem_rd;
        logic       rp_zero;
        logic [1:0] wb_data;
    } ex_ctrl_t;

    // A bubble kills every side effect but leaves the passive fields alone.
    function automatic ex_ctrl_t ctrl_bubble(input ex_ctrl_t c);
        ex_ctrl_t r;
        r        = c;
        r.reg_wr = 1'b0;
        r.mem_wr = 1'b0;
        r.mem_rd = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/ex_iter_mul.sv
// Iterative shift-add multiplier: one multiplier bit per unfrozen clock,
// low XLEN bits of the product, abortable at any time.
module ex_iter_mul
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            hold,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CNT_W = $clog2(XLEN);

    ex_state_e        state_q, state_d;
    logic [XLEN-1:0]  mcand_q, mcand_d;
    logic [XLEN-1:0]  mplier_q, mplier_d;
    logic [XLEN-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  partial;
    logic             last;

    // Product including the step performed on the current edge, so the
    // final edge can hand the complete value straight to EX/MEM.
    assign partial = mplier_q[cnt_q] ? (mcand_q << cnt_q) : '0;
    assign product = acc_q + partial;
    assign last    = (cnt_q == CNT_W'(XLEN - 1));
    assign busy    = (state_q == ST_MUL);

    // Next-state logic: abort wins, hold freezes, otherwise start or step.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise any path that skips an assignment infers a latch.
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        done     = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (!hold) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mcand_d  = a;
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = ST_MUL;
                    end
                end
                ST_MUL: begin
                    acc_d = product;
                    cnt_d = cnt_q + 1'b1;
                    if (last) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, counter and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/ex_stage_pl.sv
// Execute stage with EX/MEM pipeline register, valid/stall/flush handshake
// and combinational ALU. Define EX_MUL_EN to add the iterative multiplier
// (op 11); without it op 11 is single-cycle and returns 0.
module ex_stage_pl
    import ex_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RIDX_W = 4,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic              flush,
    input  logic              mem_stall,
    input  logic              RegWr_ID,
    input  logic              MemWr_ID,
    input  logic              MemRd_ID,
    input  logic              ALUSrc_ID,
    input  logic              RPzero_ID,
    input  logic [1:0]        WBdata_ID,
    input  logic [OP_W-1:0]   ALUop_ID,
    input  logic [XLEN-1:0]   A,
    input  logic [XLEN-1:0]   B,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   npc2,
    input  logic [RIDX_W-1:0] rd2,
    output logic              ex_valid,
    output logic              RegWr_EX,
    output logic              MemWr_EX,
    output logic              MemRd_EX,
    output logic              RPzero_EX,
    output logic [1:0]        WBdata_EX,
    output logic [XLEN-1:0]   ALUout_EX,
    output logic [XLEN-1:0]   D,
    output logic [XLEN-1:0]   npc3,
    output logic [RIDX_W-1:0] rd3,
    output logic              busy
);

    localparam int SH_W = $clog2(XLEN);

    // Everything EX/MEM carries besides the result and the valid bit.
    typedef struct packed {
        ex_ctrl_t          ctrl;
        logic [RIDX_W-1:0] rd;
        logic [XLEN-1:0]   npc;
        logic [XLEN-1:0]   d;
    } ex_side_t;

    ex_side_t        side_in, side_q;
    logic [XLEN-1:0] op2, alu_res, alu_q;
    logic [SH_W-1:0] shamt;
    logic            ex_valid_q;
    logic            accept, is_mul;

    assign side_in.ctrl.reg_wr  = RegWr_ID;
    assign side_in.ctrl.mem_wr  = MemWr_ID;
    assign side_in.ctrl.mem_rd  = MemRd_ID;
    assign side_in.ctrl.rp_zero = RPzero_ID;
    assign side_in.ctrl.wb_data = WBdata_ID;
    assign side_in.rd           = rd2;
    assign side_in.npc          = npc2;
    assign side_in.d            = B;

    assign op2      = ALUSrc_ID ? imm : B;
    assign shamt    = op2[SH_W-1:0];
    assign id_ready = !busy && !mem_stall;
    // A flush on the same edge discards whatever ID is offering.
    assign accept   = id_valid && id_ready && !flush;

    // Single-cycle ALU; MUL is handled by the iterative core when present.
    always_comb begin
        alu_res = '0;
        case (ALUop_ID)
            OP_W'(ALU_ADD):  alu_res = A + op2;
            OP_W'(ALU_SUB):  alu_res = A - op2;
            OP_W'(ALU_OR):   alu_res = A | op2;
            OP_W'(ALU_NOR):  alu_res = ~(A | op2);
            OP_W'(ALU_AND):  alu_res = A & op2;
            OP_W'(ALU_XOR):  alu_res = A ^ op2;
            OP_W'(ALU_SLT):  alu_res = XLEN'($signed(A) < $signed(op2));
            OP_W'(ALU_SLTU): alu_res = XLEN'(A < op2);
            OP_W'(ALU_SLL):  alu_res = A << shamt;
            OP_W'(ALU_SRL):  alu_res = A >> shamt;
            OP_W'(ALU_SRA):  alu_res = $unsigned($signed(A) >>> shamt);
            default:         alu_res = '0;
        endcase
    end

`ifdef EX_MUL_EN
    logic            mul_done;
    logic [XLEN-1:0] mul_prod;
    ex_side_t        pend_q;

    assign is_mul = (ALUop_ID == OP_W'(ALU_MUL));

    ex_iter_mul #(.XLEN(XLEN)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .abort   (flush),
        .hold    (mem_stall),
        .a       (A),
        .b       (op2),
        .busy    (busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Side fields of the multiply in flight, released with the product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pend_q <= '0;
        else if (accept && is_mul)
            pend_q <= side_in;
    end
`else
    assign is_mul = 1'b0;
    assign busy   = 1'b0;
`endif

    // EX/MEM register: flush beats stall, completion beats new issue,
    // anything else unfrozen inserts a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            side_q     <= '0;
            alu_q      <= '0;
        end else if (flush) begin
            ex_valid_q  <= 1'b0;
            side_q.ctrl <= ctrl_bubble(side_q.ctrl);
        end else if (!mem_stall) begin
`ifdef EX_MUL_EN
            if (mul_done) begin
                ex_valid_q <= 1'b1;
                side_q     <= pend_q;
                alu_q      <= mul_prod;
            end else
`endif
            if (accept && !is_mul) begin
                ex_valid_q <= 1'b1;
                side_q     <= side_in;
                alu_q      <= alu_res;
            end else begin
                ex_valid_q  <= 1'b0;
                side_q.ctrl <= ctrl_bubble(side_q.ctrl);
            end
        end
    end

    assign ex_valid  = ex_valid_q;
    assign RegWr_EX  = side_q.ctrl.reg_wr;
    assign MemWr_EX  = side_q.ctrl.mem_wr;
    assign MemRd_EX  = side_q.ctrl.mem_rd;
    assign RPzero_EX = side_q.ctrl.rp_zero;
    assign WBdata_EX = side_q.ctrl.wb_data;
    assign ALUout_EX = alu_q;
    assign D         = side_q.d;
    assign npc3      = side_q.npc;
    assign rd3       = side_q.rd;

endmodule

// File: tb/tb_ex_stage_pl.sv
// Self-checking bench for ex_stage_pl: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_ex_stage_pl;

    localparam int XLEN   = 32;
    localparam int RIDX_W = 4;
    localparam int OP_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid, flush, mem_stall;
    logic              RegWr_ID, MemWr_ID, MemRd_ID, ALUSrc_ID, RPzero_ID;
    logic [1:0]        WBdata_ID;
    logic [OP_W-1:0]   ALUop_ID;
    logic [XLEN-1:0]   A, B, imm, npc2;
    logic [RIDX_W-1:0] rd2;
    logic              id_ready, ex_valid, busy;
    logic              RegWr_EX, MemWr_EX, MemRd_EX, RPzero_EX;
    logic [1:0]        WBdata_EX;
    logic [XLEN-1:0]   ALUout_EX, D, npc3;
    logic [RIDX_W-1:0] rd3;

    always #5 clk = ~clk;

    ex_stage_pl #(.XLEN(XLEN), .RIDX_W(RIDX_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .flush(flush), .mem_stall(mem_stall),
        .RegWr_ID(RegWr_ID), .MemWr_ID(MemWr_ID), .MemRd_ID(MemRd_ID),
        .ALUSrc_ID(ALUSrc_ID), .RPzero_ID(RPzero_ID), .WBdata_ID(WBdata_ID),
        .ALUop_ID(ALUop_ID), .A(A), .B(B), .imm(imm), .npc2(npc2), .rd2(rd2),
        .ex_valid(ex_valid), .RegWr_EX(RegWr_EX), .MemWr_EX(MemWr_EX),
        .MemRd_EX(MemRd_EX), .RPzero_EX(RPzero_EX), .WBdata_EX(WBdata_EX),
        .ALUout_EX(ALUout_EX), .D(D), .npc3(npc3), .rd3(rd3), .busy(busy)
    );

    // Expected EX/MEM contents.
    typedef struct {
        logic              v, rw, mw, mr, rz;
        logic [1:0]        wb;
        logic [XLEN-1:0]   alu, d, npc;
        logic [RIDX_W-1:0] rd;
    } exp_t;

    exp_t exp_o, mul_fields;
    bit   mul_active;
    int   mul_left;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference ALU written straight from the op table.
    function automatic logic [XLEN-1:0] ref_alu(input int op, input logic [XLEN-1:0] x,
                                                input logic [XLEN-1:0] y);
        int          sx, sy, sh;
        logic [63:0] ext;
        sx = x;
        sy = y;
        sh = y % XLEN;
        case (op)
            0:  return x + y;
            1:  return x - y;
            2:  return x | y;
            3:  return ~(x | y);
            4:  return x & y;
            5:  return x ^ y;
            6:  return (sx < sy) ? 32'd1 : 32'd0;
            7:  return (x < y) ? 32'd1 : 32'd0;
            8:  return x << sh;
            9:  return x >> sh;
            10: begin
                ext = {{32{x[31]}}, x};
                ext = ext >> sh;
                return ext[31:0];
            end
            default: return '0;
        endcase
    endfunction

    task automatic model_reset();
        exp_o      = '{default: '0};
        mul_fields = '{default: '0};
        mul_active = 0;
        mul_left   = 0;
    endtask

    task automatic bubble();
        exp_o.v  = 0;
        exp_o.rw = 0;
        exp_o.mw = 0;
        exp_o.mr = 0;
    endtask

    // Predict the effect of the coming clock edge from the current inputs.
    task automatic model_edge();
        exp_t            nf;
        logic [XLEN-1:0] y;
        if (flush) begin
            bubble();
            mul_active = 0;
        end else if (!mem_stall) begin
            if (mul_active) begin
                mul_left--;
                if (mul_left == 0) begin
                    exp_o      = mul_fields;
                    mul_active = 0;
                end else begin
                    bubble();
                end
            end else if (id_valid) begin
                y      = ALUSrc_ID ? imm : B;
                nf.v   = 1;
                nf.rw  = RegWr_ID;
                nf.mw  = MemWr_ID;
                nf.mr  = MemRd_ID;
                nf.rz  = RPzero_ID;
                nf.wb  = WBdata_ID;
                nf.d   = B;
                nf.npc = npc2;
                nf.rd  = rd2;
                nf.alu = ref_alu(int'(ALUop_ID), A, y);
`ifdef EX_MUL_EN
                if (int'(ALUop_ID) == 11) begin
                    nf.alu     = A * y;
                    mul_fields = nf;
                    mul_active = 1;
                    mul_left   = XLEN;
                    bubble();
                end else
`endif
                exp_o = nf;
            end else begin
                bubble();
            end
        end
    endtask

    task automatic drive(input logic v, input int op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] im, input logic src);
        id_valid  = v;
        ALUop_ID  = OP_W'(op);
        A         = a;
        B         = b;
        imm       = im;
        ALUSrc_ID = src;
        RegWr_ID  = 1'($urandom);
        MemWr_ID  = 1'($urandom);
        MemRd_ID  = 1'($urandom);
        RPzero_ID = 1'($urandom);
        WBdata_ID = 2'($urandom);
        npc2      = $urandom;
        rd2       = RIDX_W'($urandom);
        flush     = 1'b0;
        mem_stall = 1'b0;
    endtask

    // One clock: check handshake, advance model, check EX/MEM after edge.
    task automatic step();
        #1;
        check("id_ready", id_ready, !mul_active && !mem_stall);
        check("busy_pre", busy, mul_active);
        model_edge();
        @(posedge clk);
        #1;
        check("ex_valid", ex_valid, exp_o.v);
        check("RegWr_EX", RegWr_EX, exp_o.rw);
        check("MemWr_EX", MemWr_EX, exp_o.mw);
        check("MemRd_EX", MemRd_EX, exp_o.mr);
        check("RPzero_EX", RPzero_EX, exp_o.rz);
        check("WBdata_EX", WBdata_EX, exp_o.wb);
        check("ALUout_EX", ALUout_EX, exp_o.alu);
        check("D", D, exp_o.d);
        check("npc3", npc3, exp_o.npc);
        check("rd3", rd3, exp_o.rd);
        check("busy_post", busy, mul_active);
        @(negedge clk);
    endtask

    task automatic check_reset_state();
        check("rst_ex_valid", ex_valid, 0);
        check("rst_ctrl", {RegWr_EX, MemWr_EX, MemRd_EX, RPzero_EX, WBdata_EX}, 0);
        check("rst_ALUout", ALUout_EX, 0);
        check("rst_D", D, 0);
        check("rst_npc3", npc3, 0);
        check("rst_rd3", rd3, 0);
        check("rst_busy", busy, 0);
        check("rst_id_ready", id_ready, 1);
    endtask

    logic [XLEN-1:0] ma, mb;

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #3;
        check_reset_state();
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back single-cycle ops.
        drive(1, 0, 5, 7, 0, 0);
        step();
        check("add_result", ALUout_EX, 32'd12);
        check("add_valid", ex_valid, 1);
        drive(1, 1, 3, 5, 0, 0);
        step();
        check("sub_result", ALUout_EX, 32'hFFFF_FFFE);
        drive(1, 10, 32'h8000_0000, 4, 0, 0);
        step();
        check("sra_result", ALUout_EX, 32'hF800_0000);
        check("sra_valid", ex_valid, 1);

        // MUL 0xFFFF x 0x10001 with ID holding its request.
        drive(1, 11, 32'h0000_FFFF, 32'h0001_0001, 0, 0);
        step();
        id_valid = 1'b0;
        for (int i = 1; i <= XLEN; i++) step();
`ifdef EX_MUL_EN
        check("mul_result", ALUout_EX, 32'hFFFF_FFFF);
        check("mul_valid", ex_valid, 1);
`endif

        // MUL with a 3-cycle stall in the middle.
        ma = $urandom;
        mb = $urandom;
        drive(1, 11, ma, mb, 0, 0);
        step();
        id_valid = 1'b0;
        for (int e = 1; e <= XLEN + 3; e++) begin
            mem_stall = (e >= 11 && e <= 13);
            step();
        end
        mem_stall = 1'b0;
`ifdef EX_MUL_EN
        check("mul_stall_result", ALUout_EX, ma * mb);
        check("mul_stall_valid", ex_valid, 1);
`endif

        // Flush on the 10th MUL cycle; nothing must come out afterwards.
        drive(1, 11, $urandom, $urandom, 0, 0);
        step();
        id_valid = 1'b0;
        for (int i = 1; i < 10; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_valid", ex_valid, 0);
        for (int i = 0; i < XLEN + 4; i++) step();
        drive(1, 0, 100, 23, 0, 0);
        step();
        check("post_flush_add", ALUout_EX, 32'd123);
        check("post_flush_valid", ex_valid, 1);

        // Flush and stall together while a store is offered.
        drive(1, 0, $urandom, $urandom, 0, 0);
        MemWr_ID  = 1'b1;
        flush     = 1'b1;
        mem_stall = 1'b1;
        step();
        check("sw_memwr", MemWr_EX, 0);
        check("sw_valid", ex_valid, 0);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check("sw_discarded", ex_valid, 0);

        // Asynchronous reset in the middle of a multiply.
        drive(1, 11, $urandom, $urandom, 0, 0);
        step();
        id_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        #2;
        rst = 1'b1;
        #1;
        check_reset_state();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < XLEN + 2; i++) step();

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            int op;
            op = ($urandom_range(0, 9) == 0) ? 11 : $urandom_range(0, 15);
            drive(($urandom_range(0, 9) < 7), op, $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                  $urandom, 1'($urandom));
            flush     = ($urandom_range(0, 59) == 0);
            mem_stall = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
